// File: rtl/nes_pad_responder.sv
// NES controller responder: answers console latch/pulse strobes with active-low serial button data.
// Latency: data updates one clk after each synchronized edge (SYNC_STAGES+1 clk from the pin).
// Backpressure: none; the console drives timing and protocol violations are flagged and dropped.
module nes_pad_responder #(
    parameter int SYNC_STAGES   = 2,
    parameter int MIN_LATCH_CYC = 240,
    parameter int TIMEOUT_CYC   = 4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        latch,
    input  logic        pulse,
    input  logic [7:0]  buttons,
    output logic        data,
    output logic        frame_done,
    output logic        proto_err,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam int QW = $clog2(MIN_LATCH_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, QUAL, LOAD, SHIFT, DONE} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] latch_sync, pulse_sync;
    logic                   latch_d, pulse_d;
    logic [QW-1:0]          qcnt, qcnt_nxt;
    logic [TW-1:0]          tcnt, tcnt_nxt;
    logic [2:0]             bit_idx, bit_idx_nxt;
    logic [7:0]             shreg, shreg_nxt;
    logic                   data_nxt, frame_done_nxt, proto_err_nxt;
    logic [15:0]            frame_count_nxt;

    logic latch_s, pulse_s, latch_rise, latch_fall, pulse_rise;

    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign pulse_s    = pulse_sync[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_d;
    assign latch_fall = ~latch_s & latch_d;
    assign pulse_rise = pulse_s & ~pulse_d;
    assign busy       = (state == QUAL) || (state == LOAD) || (state == SHIFT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latch_sync  <= '0;
            pulse_sync  <= '0;
            latch_d     <= 1'b0;
            pulse_d     <= 1'b0;
            state       <= IDLE;
            qcnt        <= '0;
            tcnt        <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            data        <= 1'b1;
            frame_done  <= 1'b0;
            proto_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            latch_sync  <= {latch_sync[SYNC_STAGES-2:0], latch};
            pulse_sync  <= {pulse_sync[SYNC_STAGES-2:0], pulse};
            latch_d     <= latch_s;
            pulse_d     <= pulse_s;
            state       <= state_nxt;
            qcnt        <= qcnt_nxt;
            tcnt        <= tcnt_nxt;
            bit_idx     <= bit_idx_nxt;
            shreg       <= shreg_nxt;
            data        <= data_nxt;
            frame_done  <= frame_done_nxt;
            proto_err   <= proto_err_nxt;
            frame_count <= frame_count_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        qcnt_nxt        = qcnt;
        tcnt_nxt        = tcnt;
        bit_idx_nxt     = bit_idx;
        shreg_nxt       = shreg;
        data_nxt        = data;
        frame_done_nxt  = 1'b0;
        proto_err_nxt   = 1'b0;
        frame_count_nxt = frame_count;
        case (state)
            IDLE: begin
                data_nxt = 1'b1;
                if (latch_rise) begin
                    state_nxt = QUAL;
                    qcnt_nxt  = '0;
                end else if (pulse_rise) begin
                    proto_err_nxt = 1'b1;
                end
            end
            QUAL: begin
                data_nxt = 1'b1;
                if (!latch_s) begin
                    state_nxt     = IDLE;
                    proto_err_nxt = 1'b1;
                end else begin
                    proto_err_nxt = pulse_rise;
                    if (qcnt == QW'(MIN_LATCH_CYC - 1)) begin
                        // Load on entry so an immediate latch fall still sees fresh buttons
                        state_nxt = LOAD;
                        shreg_nxt = buttons;
                        data_nxt  = ~buttons[0];
                    end else begin
                        qcnt_nxt = qcnt + 1'b1;
                    end
                end
            end
            LOAD: begin
                if (latch_fall) begin
                    state_nxt   = SHIFT;
                    bit_idx_nxt = '0;
                    tcnt_nxt    = '0;
                    data_nxt    = ~shreg[0];
                end else begin
                    shreg_nxt = buttons;
                    data_nxt  = ~buttons[0];
                end
            end
            SHIFT: begin
                if (latch_rise) begin
                    state_nxt     = QUAL;
                    qcnt_nxt      = '0;
                    data_nxt      = 1'b1;
                    proto_err_nxt = 1'b1;
                end else if (pulse_rise) begin
                    tcnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt       = DONE;
                        data_nxt        = 1'b1;
                        frame_done_nxt  = 1'b1;
                        frame_count_nxt = frame_count + 16'd1;
                    end else begin
                        shreg_nxt   = {1'b0, shreg[7:1]};
                        bit_idx_nxt = bit_idx + 3'd1;
                        data_nxt    = ~shreg[1];
                    end
                end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    state_nxt     = IDLE;
                    data_nxt      = 1'b1;
                    proto_err_nxt = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            DONE: begin
                data_nxt = 1'b1;
                if (latch_rise) begin
                    state_nxt = QUAL;
                    qcnt_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                data_nxt  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder at default parameters (40 MHz cycles).
`timescale 1ns/100ps
module tb_nes_pad_responder;

    logic        clk = 1'b0;
    logic        reset, latch, pulse;
    logic [7:0]  buttons;
    logic        data, frame_done, proto_err, busy;
    logic [15:0] frame_count;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;
    int pe_cnt = 0;
    int both_cnt = 0;
    int fd0, pe0;
    logic [15:0] exp_count = 16'd0;

    nes_pad_responder dut (
        .clk(clk), .reset(reset), .latch(latch), .pulse(pulse), .buttons(buttons),
        .data(data), .frame_done(frame_done), .proto_err(proto_err),
        .frame_count(frame_count), .busy(busy)
    );

    always #12.5 clk = ~clk;

    // Strobe counters sampled away from the active edge
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (proto_err) pe_cnt++;
        if (frame_done && proto_err) both_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_once();
        pulse = 1'b1;
        wait_cyc(120);
        pulse = 1'b0;
        wait_cyc(120);
    endtask

    task automatic valid_latch(input logic [7:0] b);
        buttons = b;
        latch = 1'b1;
        wait_cyc(480);
        latch = 1'b0;
        wait_cyc(10);
    endtask

    task automatic test_reset();
        reset = 1'b0; latch = 1'b0; pulse = 1'b0; buttons = 8'h00;
        wait_cyc(3);
        checks++; if (data !== 1'b1) begin errors++; $display("FAIL reset_data: got %b want 1", data); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_pe: got %b want 0", proto_err); end
        checks++; if (frame_count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h want 0000", frame_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b1;
        wait_cyc(5);
        checks++; if (busy !== 1'b0 || data !== 1'b1) begin errors++; $display("FAIL post_reset_idle: busy=%b data=%b want 0/1", busy, data); end
    endtask

    task automatic test_basic_frame();
        logic [8:0] exp_seq;
        exp_seq = 9'b1_1111_0110;
        fd0 = fd_cnt; pe0 = pe_cnt;
        buttons = 8'b0000_1001;
        latch = 1'b1;
        wait_cyc(240);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_latch: got %b want 1", busy); end
        wait_cyc(240);
        latch = 1'b0;
        wait_cyc(10);
        checks++; if (data !== exp_seq[0]) begin errors++; $display("FAIL basic_bit0: got %b want %b", data, exp_seq[0]); end
        buttons = 8'hF6;
        for (int i = 1; i <= 8; i++) begin
            pulse = 1'b1;
            wait_cyc(10);
            checks++; if (data !== exp_seq[i]) begin errors++; $display("FAIL basic_bit%0d: got %b want %b", i, data, exp_seq[i]); end
            wait_cyc(110);
            pulse = 1'b0;
            wait_cyc(120);
        end
        exp_count = exp_count + 16'd1;
        checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL basic_fd: got %0d want 1", fd_cnt - fd0); end
        checks++; if (pe_cnt - pe0 != 0) begin errors++; $display("FAIL basic_pe: got %0d want 0", pe_cnt - pe0); end
        checks++; if (frame_count !== exp_count) begin errors++; $display("FAIL basic_count: got %h want %h", frame_count, exp_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b want 0", busy); end
        pulse_once();
        checks++; if (data !== 1'b1 || pe_cnt - pe0 != 0 || fd_cnt - fd0 != 1) begin
            errors++; $display("FAIL done_extra_pulse: data=%b pe=%0d fd=%0d want 1/0/1", data, pe_cnt - pe0, fd_cnt - fd0);
        end
    endtask

    task automatic test_short_latch();
        pe0 = pe_cnt; fd0 = fd_cnt;
        latch = 1'b1;
        wait_cyc(100);
        latch = 1'b0;
        wait_cyc(10);
        checks++; if (pe_cnt - pe0 != 1) begin errors++; $display("FAIL short_pe: got %0d want 1", pe_cnt - pe0); end
        checks++; if (busy !== 1'b0 || data !== 1'b1) begin errors++; $display("FAIL short_idle: busy=%b data=%b want 0/1", busy, data); end
        checks++; if (frame_count !== exp_count || fd_cnt != fd0) begin errors++; $display("FAIL short_count: got %h want %h", frame_count, exp_count); end
        pulse_once();
        checks++; if (pe_cnt - pe0 != 2) begin errors++; $display("FAIL idle_pulse_pe: got %0d want 2", pe_cnt - pe0); end
    endtask

    task automatic test_timeout();
        valid_latch(8'hA5);
        pe0 = pe_cnt;
        for (int i = 0; i < 3; i++) pulse_once();
        wait_cyc(3600);
        checks++; if (busy !== 1'b1 || pe_cnt != pe0) begin errors++; $display("FAIL pre_timeout: busy=%b pe=%0d want 1/0", busy, pe_cnt - pe0); end
        wait_cyc(300);
        checks++; if (pe_cnt - pe0 != 1) begin errors++; $display("FAIL timeout_pe: got %0d want 1", pe_cnt - pe0); end
        checks++; if (data !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: data=%b busy=%b want 1/0", data, busy); end
        checks++; if (frame_count !== exp_count) begin errors++; $display("FAIL timeout_count: got %h want %h", frame_count, exp_count); end
    endtask

    task automatic test_relatch();
        logic [7:0] bv;
        bv = 8'h5A;
        valid_latch(8'h3C);
        pe0 = pe_cnt; fd0 = fd_cnt;
        for (int i = 0; i < 4; i++) pulse_once();
        checks++; if (data !== 1'b0) begin errors++; $display("FAIL relatch_bit4: got %b want 0", data); end
        latch = 1'b1; pulse = 1'b1;
        wait_cyc(10);
        checks++; if (busy !== 1'b1 || data !== 1'b1) begin errors++; $display("FAIL relatch_qual: busy=%b data=%b want 1/1", busy, data); end
        checks++; if (pe_cnt - pe0 != 1 || fd_cnt != fd0) begin errors++; $display("FAIL relatch_pe: pe=%0d fd=%0d want 1/0", pe_cnt - pe0, fd_cnt - fd0); end
        wait_cyc(110);
        pulse = 1'b0; buttons = bv;
        wait_cyc(180);
        pulse = 1'b1;
        wait_cyc(60);
        checks++; if (busy !== 1'b1 || pe_cnt - pe0 != 1) begin errors++; $display("FAIL load_pulse: busy=%b pe=%0d want 1/1", busy, pe_cnt - pe0); end
        pulse = 1'b0;
        wait_cyc(120);
        latch = 1'b0;
        wait_cyc(10);
        checks++; if (data !== ~bv[0]) begin errors++; $display("FAIL relatch_new_bit0: got %b want %b", data, ~bv[0]); end
        buttons = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            pulse = 1'b1;
            wait_cyc(10);
            checks++;
            if (data !== ((i == 8) ? 1'b1 : ~bv[i])) begin errors++; $display("FAIL relatch_new_bit%0d: got %b", i, data); end
            wait_cyc(110);
            pulse = 1'b0;
            wait_cyc(120);
        end
        exp_count = exp_count + 16'd1;
        checks++; if (fd_cnt - fd0 != 1 || frame_count !== exp_count) begin errors++; $display("FAIL relatch_frame: fd=%0d count=%h want 1/%h", fd_cnt - fd0, frame_count, exp_count); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.frame_count = 16'hFFFF;
        wait_cyc(2);
        release dut.frame_count;
        wait_cyc(2);
        checks++; if (frame_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffff", frame_count); end
        fd0 = fd_cnt;
        valid_latch(8'h00);
        for (int i = 0; i < 8; i++) pulse_once();
        exp_count = 16'h0000;
        checks++; if (frame_count !== exp_count) begin errors++; $display("FAIL wrap_count: got %h want 0000", frame_count); end
        checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL wrap_fd: got %0d want 1", fd_cnt - fd0); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] bv;
        valid_latch(8'hB4);
        for (int i = 0; i < 5; i++) pulse_once();
        checks++; if (data !== 1'b0) begin errors++; $display("FAIL mid_bit5: got %b want 0", data); end
        fd0 = fd_cnt; pe0 = pe_cnt;
        reset = 1'b0;
        #1;
        checks++; if (data !== 1'b1 || busy !== 1'b0 || frame_count !== 16'h0000) begin
            errors++; $display("FAIL mid_reset_outputs: data=%b busy=%b count=%h want 1/0/0000", data, busy, frame_count);
        end
        wait_cyc(5);
        checks++; if (fd_cnt != fd0 || pe_cnt != pe0) begin errors++; $display("FAIL mid_reset_strobe: fd=%0d pe=%0d want 0/0", fd_cnt - fd0, pe_cnt - pe0); end
        reset = 1'b1;
        wait_cyc(5);
        bv = 8'hC3;
        valid_latch(bv);
        checks++; if (data !== ~bv[0]) begin errors++; $display("FAIL post_bit0: got %b want %b", data, ~bv[0]); end
        for (int i = 1; i <= 8; i++) begin
            pulse = 1'b1;
            wait_cyc(10);
            checks++;
            if (data !== ((i == 8) ? 1'b1 : ~bv[i])) begin errors++; $display("FAIL post_bit%0d: got %b", i, data); end
            wait_cyc(110);
            pulse = 1'b0;
            wait_cyc(120);
        end
        checks++; if (frame_count !== 16'h0001 || fd_cnt - fd0 != 1) begin errors++; $display("FAIL post_frame: count=%h fd=%0d want 0001/1", frame_count, fd_cnt - fd0); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_short_latch();
        test_timeout();
        test_relatch();
        test_wrap();
        test_reset_midframe();
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nes_pad_responder.md
NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

Interface
REQ-001 The block SHALL be a single clock domain with asynchronous active-low reset; reset deasserts synchronously to clk.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for latch and pulse inputs, minimum 2.
REQ-003 Parameter MIN_LATCH_CYC, default 240: consecutive synced-high cycles qualifying a latch (6 us at 40 MHz).
REQ-004 Parameter TIMEOUT_CYC, default 4000: max cycles in SHIFT without a pulse edge (100 us at 40 MHz).
REQ-005 clk  input  1  40 MHz system clock.
REQ-006 reset  input  1  asynchronous reset, active-low.
REQ-007 latch  input  1  console latch strobe, asynchronous, active-high.
REQ-008 pulse  input  1  console shift clock, asynchronous, active-high.
REQ-009 buttons  input  8  pressed=1; bit order [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
REQ-010 data  output  1  serial button data to console, active-low (0 = pressed), registered.
REQ-011 frame_done  output  1  one-cycle strobe on completion of an 8-bit read.
REQ-012 proto_err  output  1  one-cycle strobe on a protocol violation.
REQ-013 frame_count  output  16  completed reads, wraps 0xFFFF->0x0000.
REQ-014 busy  output  1  high in QUAL, LOAD, SHIFT.

Function
REQ-015 latch and pulse SHALL each pass through SYNC_STAGES flops reset to 0; rising/falling edges detected on the synced signals only.
REQ-016 FSM states: IDLE, QUAL, LOAD, SHIFT, DONE; reset state IDLE.
REQ-017 IDLE: data=1; synced latch rise -> QUAL, qual counter cleared.
REQ-018 QUAL: counter increments while latch high; reaching MIN_LATCH_CYC-1 -> LOAD; latch falls earlier -> IDLE plus proto_err strobe.
REQ-019 LOAD: shift register reloaded from buttons every cycle; data = ~buttons[0] registered (one-cycle latency); synced latch fall -> SHIFT, bit index=0, last loaded value frozen.
REQ-020 SHIFT: each synced pulse rise shifts register right, filling 0, bit index +1; data = ~shreg[0] so bits 1..7 appear after pulses 1..7.
REQ-021 8th pulse rise in SHIFT -> DONE, data=1, frame_done strobe, frame_count +1 same cycle.
REQ-022 DONE: data held 1; further pulse rises ignored without error; latch rise -> QUAL.
REQ-023 SHIFT timeout: TIMEOUT_CYC cycles without pulse rise -> IDLE, data=1, proto_err strobe, frame_count unchanged.
REQ-024 Latch rise in SHIFT (early re-latch) -> QUAL, partial frame discarded, proto_err strobe.
REQ-025 Pulse rise in IDLE or QUAL -> proto_err strobe, no state change.
REQ-026 Simultaneous latch rise and pulse rise in the same cycle: latch wins, pulse ignored, no shift.
REQ-027 Pulse rise while latch high (LOAD) ignored; register keeps tracking buttons.
REQ-028 buttons sampled only in LOAD; changes in SHIFT/DONE do not affect the current frame.
REQ-029 proto_err and frame_done never assert in the same cycle.

Reset
REQ-030 On reset low, immediately: state=IDLE, data=1, frame_done=0, proto_err=0, frame_count=0, busy=0, synchronizers, shift register and all counters=0.
REQ-031 Reset asserted mid-frame aborts without a frame_done or proto_err strobe; first post-reset frame starts from IDLE.

Verification
REQ-032 buttons=8'b0000_1001, 12 us latch, 8 pulses at 6 us spacing -> data sequence 0,1,1,0,1,1,1,1 then 1; one frame_done; frame_count=1.
REQ-033 Latch high 100 cycles (<240) -> proto_err once, state IDLE, data=1, frame_count unchanged.
REQ-034 Valid latch, 3 pulses, then 4000 idle cycles -> proto_err at timeout, data=1, frame_count unchanged.
REQ-035 Valid latch, 4 pulses, new latch rise coincident with pulse -> no shift, QUAL entered, new frame reads fresh buttons correctly.
REQ-036 frame_count preloaded to 0xFFFF by 65535 frames, one more frame -> 0x0000, frame_done asserted.
REQ-037 Reset low during bit 5 of SHIFT -> all outputs at REQ-030 values next cycle; no strobe; subsequent full frame correct.
